// File: rtl/seven_segment_display_scanner_if.sv
// Bus between a value producer and the seven-segment scan controller:
// load strobe with value/mask/blank flag in, scanned digit drive out.
interface seven_segment_display_scanner_if #(
  parameter int NUMBER_OF_SEVEN_SEGMENT_LEDS = 4
);
  logic                                      load;
  logic [4*NUMBER_OF_SEVEN_SEGMENT_LEDS-1:0] value_bcd;
  logic [NUMBER_OF_SEVEN_SEGMENT_LEDS-1:0]   dp_mask;
  logic                                      blank_leading_zeros;
  logic [3:0]                                bcd;
  logic [NUMBER_OF_SEVEN_SEGMENT_LEDS-1:0]   seven_seg_led_number;
  logic                                      digit_dp_n;
  logic                                      frame_done;

  modport master (
    output load, value_bcd, dp_mask, blank_leading_zeros,
    input  bcd, seven_seg_led_number, digit_dp_n, frame_done
  );

  modport slave (
    input  load, value_bcd, dp_mask, blank_leading_zeros,
    output bcd, seven_seg_led_number, digit_dp_n, frame_done
  );
endinterface

// File: rtl/seven_segment_display_scanner.sv
// Time-multiplexed scanner for an N-digit common-anode display with
// double-buffered value, per-digit dead time and leading-zero blanking.
module seven_segment_display_scanner #(
  parameter int NUMBER_OF_SEVEN_SEGMENT_LEDS = 4,
  parameter int REFRESH_DIVIDER              = 50000
) (
  input  logic clk,
  input  logic rst_n,
  seven_segment_display_scanner_if.slave bus
);
  localparam int N  = NUMBER_OF_SEVEN_SEGMENT_LEDS;
  localparam int CW = $clog2(REFRESH_DIVIDER);
  localparam int IW = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIVIDER - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

  typedef enum logic {BLANK, DRIVE} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   prescale;
  logic            tick;
  logic [IW-1:0]   index;
  logic            wrap;
  logic            armed;

  logic [4*N-1:0]  shadow_value, active_value;
  logic [N-1:0]    shadow_dp, active_dp;
  logic            shadow_blank, active_blank, pending;

  logic [3:0]      bcd_q, bcd_next;
  logic [N-1:0]    anode_q, anode_next;
  logic            dp_n_q, dp_n_next;
  logic            frame_done_q;

  logic [N-1:0]    suppress;
  logic            lead;
  logic [4*N-1:0]  digit_shifted;

  assign tick = (prescale == CNT_LAST);
  assign wrap = tick && (index == IDX_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescale <= '0;
    end else if (tick) begin
      prescale <= '0;
    end else begin
      prescale <= prescale + CW'(1);
    end
  end

  // armed keeps the display dark until the first tick after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index        <= IDX_LAST;
      armed        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= wrap;
      if (tick) begin
        index <= (index == IDX_LAST) ? '0 : index + IW'(1);
        armed <= 1'b1;
      end
    end
  end

  // Commit uses the pre-edge shadow, so a load on the wrap stays pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_value <= '0;
      shadow_dp    <= '0;
      shadow_blank <= 1'b0;
      pending      <= 1'b0;
      active_value <= '0;
      active_dp    <= '0;
      active_blank <= 1'b0;
    end else begin
      if (wrap && pending) begin
        active_value <= shadow_value;
        active_dp    <= shadow_dp;
        active_blank <= shadow_blank;
      end
      if (bus.load) begin
        shadow_value <= bus.value_bcd;
        shadow_dp    <= bus.dp_mask;
        shadow_blank <= bus.blank_leading_zeros;
        pending      <= 1'b1;
      end else if (wrap) begin
        pending <= 1'b0;
      end
    end
  end

  always_comb begin
    lead     = 1'b1;
    suppress = '0;
    for (int i = N - 1; i >= 1; i--) begin
      lead        = lead & (active_value[4*i +: 4] == 4'h0);
      suppress[i] = active_blank & lead;
    end
  end

  assign digit_shifted = active_value >> {index, 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= BLANK;
      bcd_q   <= 4'hF;
      anode_q <= '1;
      dp_n_q  <= 1'b1;
    end else begin
      state   <= state_next;
      bcd_q   <= bcd_next;
      anode_q <= anode_next;
      dp_n_q  <= dp_n_next;
    end
  end

  always_comb begin
    state_next = state;
    bcd_next   = bcd_q;
    anode_next = anode_q;
    dp_n_next  = dp_n_q;
    case (state)
      DRIVE: begin
        if (tick) begin
          state_next = BLANK;
          bcd_next   = 4'hF;
          anode_next = '1;
          dp_n_next  = 1'b1;
        end
      end
      BLANK: begin
        if (armed) begin
          state_next = DRIVE;
          anode_next = ~(N'(1) << index);
          bcd_next   = suppress[index] ? 4'hF : digit_shifted[3:0];
          dp_n_next  = ~active_dp[index];
        end
      end
      default: state_next = BLANK;
    endcase
  end

  assign bus.bcd                  = bcd_q;
  assign bus.seven_seg_led_number = anode_q;
  assign bus.digit_dp_n           = dp_n_q;
  assign bus.frame_done           = frame_done_q;
endmodule

// File: doc/seven_segment_display_scanner.md
# seven_segment_display_scanner

Time-multiplexed scan controller for the common-anode, active-low seven-segment display. Holds one N-digit BCD value, steps through the digits at a programmable refresh rate, and presents one digit at a time on `bcd`, together with the active-low digit enable and decimal point. `bcd` connects directly to the BCD-to-segment decoder's `bcd` input. `seven_seg_led_number` and `digit_dp_n` drive the display; the top level ANDs `digit_dp_n` into decoder segment bit 7. New values are double-buffered and take effect only at a frame boundary, so a displayed frame never mixes old and new digits.

## Interface
- `NUMBER_OF_SEVEN_SEGMENT_LEDS`, default 4: number of digits N. Legal range is N ≥ 2.
- `REFRESH_DIVIDER`, default 50000: number of clk cycles per digit slot. Legal range is ≥ 2.
- `clk` input, 1 bit: single clock. All logic is rising-edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `load` input, 1 bit: one-cycle strobe. Captures `value_bcd`, `dp_mask` and `blank_leading_zeros`.
- `value_bcd` input, 4·N bits: digit i occupies bits [4i+3:4i]. Digit 0 is least significant and rightmost.
- `dp_mask` input, N bits: a 1 in bit i lights the decimal point of digit i.
- `blank_leading_zeros` input, 1 bit: enables leading-zero suppression.
- `bcd` output, 4 bits: code for the currently enabled digit. 4'hF means blank, which the decoder maps to all segments off.
- `seven_seg_led_number` output, N bits: active-low digit enables. At most one bit is 0 at any time.
- `digit_dp_n` output, 1 bit: active-low decimal point for the enabled digit.
- `frame_done` output, 1 bit: one-cycle pulse on every frame wrap.

## Operation
- **Prescaler.** Counts 0 … REFRESH_DIVIDER−1 and wraps. `tick` is asserted when the count equals REFRESH_DIVIDER−1. The counter width is clog2(REFRESH_DIVIDER).
- **Shadow register.** On `load`, captures the value, mask and blank flag, and sets `pending`. A second `load` while `pending` is set overwrites the shadow; the last load wins.
- **Active register.** Used for display. On a wrap tick (index N−1 → 0) with `pending` set: active ← shadow, and `pending` is cleared. If `load` and a wrap tick occur in the same cycle, the wrap commits the previous shadow contents. The new load is then held pending and commits at the next wrap.
- **Digit index.** Reset value is N−1, so the first tick wraps to 0, commits any load made after reset, and pulses `frame_done`. Each tick advances the index by 1 modulo N.
- **Dead-time state machine.** Two states, BLANK and DRIVE, both with registered outputs.
  - DRIVE → BLANK on `tick`: `seven_seg_led_number` goes to all 1s, `bcd` goes to 4'hF, `digit_dp_n` goes to 1, and the index advances.
  - BLANK → DRIVE unconditionally on the next cycle: the anode bit for the index goes low, `bcd` is set to active digit[index] (or 4'hF if suppressed), and `digit_dp_n` is set to ~active_dp[index].
  - The one-cycle blank gap prevents ghosting.
- **Leading-zero suppression.** Applies when active blank flag = 1. Digit i (i ≥ 1) is suppressed when it and every digit above it equal 0. Digit 0 is never suppressed. A suppressed digit still asserts its anode and outputs `bcd` = 4'hF. Its DP follows `dp_mask` regardless of suppression.
- **Non-decimal digit values** (10–15) pass through unchanged. The decoder blanks them.

## Timing
- **Reset values.**
  - Outputs: `seven_seg_led_number` = all 1s, `bcd` = 4'hF, `digit_dp_n` = 1, `frame_done` = 0.
  - Internal state: state = BLANK, prescaler = 0, index = N−1, shadow = active = 0 with blank flag 0 and dp mask 0, `pending` = 0.
- **After reset release.**
  - Outputs stay blank until the first tick at cycle REFRESH_DIVIDER−1.
  - `frame_done` is high in the cycle after that tick.
  - Digit 0 is driven one cycle later.
- **Per-digit slot.** 1 blank cycle followed by REFRESH_DIVIDER−1 drive cycles. A full frame is N·REFRESH_DIVIDER cycles.
- **`frame_done`** is registered. It is high during the BLANK cycle that precedes digit 0.
- **Load-to-display latency** is at most N·REFRESH_DIVIDER + 2 cycles, and always lands on a frame boundary.
- **Reset mid-frame.** Asserting `rst_n` low at any time immediately forces the reset values. Any pending load is discarded.

## Test plan
- **Reset and first frame.** N=4, DIV=4. Hold `load` low after reset. Required:
  - Cycles 0–3: all anodes 1.
  - `frame_done` pulses once.
  - Anodes then cycle 1110, 1101, 1011, 0111, each preceded by one 1111 cycle.
  - `bcd` = 0 on every digit.
- **Value and DP.** `load` with `value_bcd` = 16'h1234, `dp_mask` = 4'b0100. After the next `frame_done`, the driven sequence is:
  - `bcd` 4, 3, 2, 1 on anodes 1110, 1101, 1011, 0111.
  - `digit_dp_n` = 0 only while anode 1011 is low.
- **Leading-zero suppression.** `load` 16'h0070 with `blank_leading_zeros` = 1. Required `bcd` per digit 0..3: 0, 7, F, F. With `load` 16'h0000: 0, F, F, F.
- **Double buffering.**
  - `load` 16'h1111 mid-frame, then `load` 16'h2222 before the wrap. Required: the old value is shown until wrap, then only 2s. No frame contains mixed digits.
  - `load` coincident with the wrap tick: the value appears one full frame later.
- **Reset mid-operation.** Assert `rst_n` low during a drive slot showing 16'h5678. Required:
  - Outputs go to reset values within the same cycle, asynchronously.
  - After release, `bcd` = 0 on all digits. The 5678 is gone.
- **Non-BCD passthrough.** `load` 16'hABC9. Required `bcd` per digit 0..3: 9, C, B, A, with anode timing unchanged.
